// File: rtl/encoder_pkg.sv
// Shared types and quadrature decode for the encoder bank.
// Quadrature states are {a,b}; forward order is 00,01,11,10.
package encoder_pkg;

  typedef logic [1:0] quad_t;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_UP,
    STEP_DOWN
  } step_e;

  function automatic step_e decode(
    input quad_t prev,
    input quad_t cur,
    input logic  detent
  );
    step_e s;
    s = STEP_NONE;
    if (detent) begin
      case ({prev, cur})
        4'b1000: s = STEP_UP;
        4'b0100: s = STEP_DOWN;
        default: s = STEP_NONE;
      endcase
    end else begin
      case ({prev, cur})
        4'b0001, 4'b0111,
        4'b1110, 4'b1000: s = STEP_UP;
        4'b0010, 4'b1011,
        4'b1101, 4'b0100: s = STEP_DOWN;
        default:          s = STEP_NONE;
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/encoder_channel.sv
// One encoder channel: sync, debounce, decode, position.
// Write to the position wins over a same-cycle count.
module encoder_channel
  import encoder_pkg::*;
#(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DETENT_MODE     = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] pos,
  output logic             count_evt
);

  localparam logic [7:0] CNT_LAST =
    8'(DEBOUNCE_CYCLES - 1);
  localparam logic DETENT = (DETENT_MODE != 0);

  quad_t      sync1;
  quad_t      sync2;
  quad_t      filt;
  logic [7:0] cnt;
  logic       accept;
  step_e      step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {a, b};
      sync2 <= sync1;
    end
  end

  always_comb begin
    accept = (sync2 != filt) && (cnt == CNT_LAST);
    step   = STEP_NONE;
    if (accept) begin
      step = decode(filt, sync2, DETENT);
    end
  end

  // filt doubles as the previous decoded state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      filt <= '0;
    end else if (sync2 == filt) begin
      cnt  <= '0;
    end else if (accept) begin
      cnt  <= '0;
      filt <= sync2;
    end else begin
      cnt  <= cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos <= '0;
    end else if (wr_en) begin
      pos <= wr_data;
    end else begin
      case (step)
        STEP_UP:   pos <= pos + WIDTH'(1);
        STEP_DOWN: pos <= pos - WIDTH'(1);
        default:   pos <= pos;
      endcase
    end
  end

  assign count_evt = (step != STEP_NONE) && !wr_en;

endmodule

// File: rtl/encoder_bank.sv
// Bank of quadrature encoder channels behind a small
// register map: positions, then a W1C CHANGED register.
module encoder_bank
  import encoder_pkg::*;
#(
  parameter int NUM_CHANNELS    = 8,
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DETENT_MODE     = 0,
  localparam int ADDR_WIDTH     = $clog2(NUM_CHANNELS) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    reg_we,
  input  logic [ADDR_WIDTH-1:0]   reg_addr,
  input  logic [WIDTH-1:0]        reg_data,
  output logic [WIDTH-1:0]        reg_q,
  input  logic [NUM_CHANNELS-1:0] a,
  input  logic [NUM_CHANNELS-1:0] b
);

  localparam logic [ADDR_WIDTH-1:0] CHG_ADDR =
    ADDR_WIDTH'(NUM_CHANNELS);

  logic [WIDTH-1:0]        pos [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] evt;
  logic [NUM_CHANNELS-1:0] wr_sel;
  logic [NUM_CHANNELS-1:0] clr;
  logic [NUM_CHANNELS-1:0] changed;

  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      wr_sel[i] = reg_we &&
        (reg_addr == ADDR_WIDTH'(i));
    end
    clr = '0;
    if (reg_we && reg_addr == CHG_ADDR) begin
      clr = reg_data[NUM_CHANNELS-1:0];
    end
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    encoder_channel #(
      .WIDTH           (WIDTH),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .DETENT_MODE     (DETENT_MODE)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .a         (a[g]),
      .b         (b[g]),
      .wr_en     (wr_sel[g]),
      .wr_data   (reg_data),
      .pos       (pos[g]),
      .count_evt (evt[g])
    );
  end

  // set beats clear when both hit the same bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      changed <= '0;
    end else begin
      changed <= (changed & ~clr) | evt;
    end
  end

  always_comb begin
    reg_q = '0;
    if (reg_addr == CHG_ADDR) begin
      reg_q[NUM_CHANNELS-1:0] = changed;
    end
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (reg_addr == ADDR_WIDTH'(i)) begin
        reg_q = pos[i];
      end
    end
  end

endmodule

// File: tb/tb_encoder_bank.sv
// Scoreboard bench: x4 and x1 banks share stimulus,
// reads are checked against a gray-index position model.
module tb_encoder_bank;

  localparam int NCH = 8;
  localparam int W   = 16;
  localparam int DEB = 4;
  localparam int AW  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          reg_we = 1'b0;
  logic [AW-1:0] reg_addr = '0;
  logic [W-1:0]  reg_data = '0;
  logic [NCH-1:0] a = '0;
  logic [NCH-1:0] b = '0;
  logic [W-1:0]  q4;
  logic [W-1:0]  q1;

  encoder_bank #(
    .NUM_CHANNELS(NCH), .WIDTH(W),
    .DEBOUNCE_CYCLES(DEB), .DETENT_MODE(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .reg_we(reg_we),
    .reg_addr(reg_addr), .reg_data(reg_data),
    .reg_q(q4), .a(a), .b(b)
  );

  encoder_bank #(
    .NUM_CHANNELS(NCH), .WIDTH(W),
    .DEBOUNCE_CYCLES(DEB), .DETENT_MODE(1)
  ) dut_det (
    .clk(clk), .rst_n(rst_n), .reg_we(reg_we),
    .reg_addr(reg_addr), .reg_data(reg_data),
    .reg_q(q1), .a(a), .b(b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [W-1:0]  e4;
    logic [W-1:0]  e1;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic rd_pend = 1'b0;

  logic [W-1:0]   m_pos4 [NCH];
  logic [W-1:0]   m_pos1 [NCH];
  logic [NCH-1:0] m_chg4;
  logic [NCH-1:0] m_chg1;
  logic [1:0]     m_ph [NCH];
  logic [1:0]     cur [NCH];
  logic [1:0]     nxt [NCH];

  // position of a phase along the forward cycle
  function automatic int gidx(input logic [1:0] v);
    return 2 * v[1] + (v[1] ^ v[0]);
  endfunction

  function automatic int step4(
    input logic [1:0] o, input logic [1:0] n);
    int d;
    d = (gidx(n) - gidx(o) + 4) % 4;
    return (d == 1) ? 1 : (d == 3) ? -1 : 0;
  endfunction

  // one detent = the x4 step that lands on 00
  function automatic int step1(
    input logic [1:0] o, input logic [1:0] n);
    return (n == 2'b00) ? step4(o, n) : 0;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_pos4[i] = '0;
      m_pos1[i] = '0;
      m_ph[i]   = 2'b00;
    end
    m_chg4 = '0;
    m_chg1 = '0;
  endfunction

  function automatic void model_move(
    input int ch, input logic [1:0] n, input bit sup);
    int s4, s1;
    s4 = step4(m_ph[ch], n);
    s1 = step1(m_ph[ch], n);
    m_ph[ch] = n;
    if (!sup) begin
      m_pos4[ch] = W'(int'(m_pos4[ch]) + s4);
      m_pos1[ch] = W'(int'(m_pos1[ch]) + s1);
      if (s4 != 0) m_chg4[ch] = 1'b1;
      if (s1 != 0) m_chg1[ch] = 1'b1;
    end
  endfunction

  function automatic logic [W-1:0] exp_val(
    input logic [AW-1:0] ad, input bit det);
    if (int'(ad) < NCH)
      return det ? m_pos1[int'(ad)] : m_pos4[int'(ad)];
    if (int'(ad) == NCH)
      return {8'h00, det ? m_chg1 : m_chg4};
    return '0;
  endfunction

  function automatic void model_write(
    input int ad, input logic [W-1:0] d);
    if (ad < NCH) begin
      m_pos4[ad] = d;
      m_pos1[ad] = d;
    end else if (ad == NCH) begin
      m_chg4 = m_chg4 & ~d[NCH-1:0];
      m_chg1 = m_chg1 & ~d[NCH-1:0];
    end
  endfunction

  task automatic set_raw();
    for (int i = 0; i < NCH; i++) begin
      a[i] = cur[i][1];
      b[i] = cur[i][0];
    end
  endtask

  task automatic do_read(input logic [AW-1:0] ad);
    exp_t e;
    e.addr = ad;
    e.e4   = exp_val(ad, 1'b0);
    e.e1   = exp_val(ad, 1'b1);
    sb.push_back(e);
    @(posedge clk); #1;
    reg_addr = ad;
    rd_pend  = 1'b1;
    @(posedge clk); #1;
    rd_pend  = 1'b0;
  endtask

  task automatic cpu_write(input int ad, input logic [W-1:0] d);
    @(posedge clk); #1;
    reg_we   = 1'b1;
    reg_addr = AW'(ad);
    reg_data = d;
    @(posedge clk); #1;
    reg_we   = 1'b0;
    model_write(ad, d);
  endtask

  task automatic move(input int hold);
    for (int i = 0; i < NCH; i++) begin
      model_move(i, nxt[i], 1'b0);
      cur[i] = nxt[i];
    end
    @(posedge clk); #1;
    set_raw();
    repeat (hold) @(posedge clk);
  endtask

  task automatic move1(input int ch, input logic [1:0] v);
    nxt = cur;
    nxt[ch] = v;
    move(10);
  endtask

  // write lands on the same edge the step is accepted
  task automatic collide(input int ch, input logic [1:0] v,
                         input int ad, input logic [W-1:0] d);
    @(posedge clk); #1;
    cur[ch] = v;
    set_raw();
    repeat (DEB + 1) @(posedge clk);
    #1;
    reg_we   = 1'b1;
    reg_addr = AW'(ad);
    reg_data = d;
    @(posedge clk); #1;
    reg_we   = 1'b0;
    if (ad == ch) begin
      model_move(ch, v, 1'b1);
      model_write(ad, d);
    end else begin
      model_write(ad, d);
      model_move(ch, v, 1'b0);
    end
    repeat (4) @(posedge clk);
  endtask

  task automatic glitch(input int ch, input int k);
    @(posedge clk); #1;
    cur[ch] = cur[ch] ^ 2'b10;
    set_raw();
    repeat (k) @(posedge clk);
    #1;
    cur[ch] = cur[ch] ^ 2'b10;
    set_raw();
    repeat (DEB + 4) @(posedge clk);
  endtask

  always @(negedge clk) begin
    if (rd_pend) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_empty: read with no expectation");
      end else begin
        mon_e = sb.pop_front();
        n_cmp++;
        if (q4 !== mon_e.e4) begin
          n_bad++;
          $display("FAIL x4_read addr=%0d got %h want %h",
                   mon_e.addr, q4, mon_e.e4);
        end
        n_cmp++;
        if (q1 !== mon_e.e1) begin
          n_bad++;
          $display("FAIL x1_read addr=%0d got %h want %h",
                   mon_e.addr, q1, mon_e.e1);
        end
      end
    end
  end

  initial begin
    #2000000;
    n_bad++;
    $display("FAIL watchdog: bench did not finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    int op;
    int ch;
    model_reset();
    for (int i = 0; i < NCH; i++) cur[i] = 2'b00;
    set_raw();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 16; i++) do_read(AW'(i));

    // full forward cycle on channel 2
    move1(2, 2'b01);
    move1(2, 2'b11);
    move1(2, 2'b10);
    move1(2, 2'b00);
    for (int i = 0; i <= NCH; i++) do_read(AW'(i));

    // full reverse cycle on channel 0
    move1(0, 2'b10);
    move1(0, 2'b11);
    move1(0, 2'b01);
    move1(0, 2'b00);
    do_read(0);
    do_read(AW'(NCH));

    // position write collides with a count
    collide(1, 2'b01, 1, 16'h7FFF);
    do_read(1);
    move1(1, 2'b11);
    do_read(1);

    // W1C collides with a count on channel 1
    cpu_write(NCH, 16'hFFFF);
    nxt = cur;
    nxt[0] = 2'b01;
    nxt[1] = 2'b10;
    move(10);
    do_read(AW'(NCH));
    collide(1, 2'b00, NCH, 16'h0001);
    do_read(AW'(NCH));
    do_read(1);

    // short glitch on a[5]
    cpu_write(NCH, 16'hFFFF);
    glitch(5, DEB - 1);
    do_read(5);
    do_read(AW'(NCH));

    // reset in the middle of a rotation
    cpu_write(3, 16'h0010);
    do_read(3);
    @(posedge clk); #1;
    cur[3] = cur[3] ^ 2'b01;
    set_raw();
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NCH; i++) cur[i] = 2'b00;
    set_raw();
    rst_n = 1'b0;
    model_reset();
    mon_e.addr = 3;
    mon_e.e4 = exp_val(3, 1'b0);
    mon_e.e1 = exp_val(3, 1'b1);
    sb.push_back(mon_e);
    reg_addr = 3;
    rd_pend  = 1'b1;
    @(posedge clk); #1;
    rd_pend = 1'b0;
    rst_n   = 1'b1;
    repeat (DEB + 6) @(posedge clk);
    for (int i = 0; i <= NCH; i++) do_read(AW'(i));

    for (int it = 0; it < 80; it++) begin
      op = $urandom_range(0, 9);
      if (op < 6) begin
        for (int i = 0; i < NCH; i++)
          nxt[i] = ($urandom_range(0, 2) == 0) ?
                   2'($urandom) : cur[i];
        move(DEB + 4);
      end else if (op == 6) begin
        ch = $urandom_range(0, NCH - 1);
        glitch(ch, $urandom_range(1, DEB - 1));
      end else if (op == 7) begin
        cpu_write($urandom_range(0, NCH - 1), W'($urandom));
      end else if (op == 8) begin
        cpu_write(NCH, W'($urandom));
      end else begin
        cpu_write($urandom_range(NCH + 1, 15), W'($urandom));
      end
      do_read(AW'($urandom_range(0, NCH)));
      do_read(AW'($urandom));
    end

    repeat (5) @(posedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sb_drain: %0d left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
